chunked_add_seq: RTL and testbench
==================================

// Module: chunked_add_seq
// PURPOSE
//   Multi-cycle sequencer placed directly upstream of the N-bit Adder. Accepts
//   one wide operand pair, W = N*CHUNKS bits, over a valid/ready handshake.
//   Feeds the pair to the adder one N-bit chunk per cycle, LSB chunk first,
//   chaining the adder carry between chunks. Collects the wide sum, carry-out
//   and signed overflow, then presents them over an output valid/ready handshake.
// PARAMETERS
//   N       8  chunk width; must equal the Adder N it drives
//   CHUNKS  4  chunks per operand (>=1); W = N*CHUNKS
// PORTS
//   clk        in   1  sole clock, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  operand pair valid
//   in_ready   out  1  sequencer can accept (IDLE only)
//   in_a       in   W  operand A
//   in_b       in   W  operand B
//   in_cin     in   1  carry-in to chunk 0
//   add_a      out  N  to Adder .a
//   add_b      out  N  to Adder .b
//   add_cin    out  1  to Adder .cin
//   add_sum    in   N  from Adder .sum (combinational, same cycle)
//   add_cout   in   1  from Adder .cout
//   out_valid  out  1  result valid
//   out_ready  in   1  consumer accepts result
//   out_sum    out  W  wide sum
//   out_cout   out  1  carry out of MSB chunk
//   out_ovf    out  1  two's-complement overflow of the W-bit add
// BEHAVIOUR
//   Clock and reset
//   - One clock: clk. Reset rst_n is asynchronous and active-low.
//   - Reset (any time, including mid-RUN): state=IDLE, idx=0, carry=0.
//     All result and operand registers are cleared to 0. out_valid=0.
//     The operation in flight is abandoned, with no partial output.
//   - After reset release, in_ready=1 from the first cycle.
//   FSM: IDLE -> RUN -> DONE -> IDLE
//   - IDLE: in_ready=1. add_a=0, add_b=0, add_cin=0.
//     On in_valid&in_ready at a clock edge: latch in_a/in_b, carry<=in_cin,
//     idx<=0, go to RUN.
//   - RUN: in_ready=0.
//     add_a=opA[idx*N +: N]; add_b=opB[idx*N +: N]; add_cin=carry.
//     Each edge: res[idx*N +: N]<=add_sum; carry<=add_cout.
//     If idx==CHUNKS-1, go to DONE; else idx<=idx+1.
//   - DONE: out_valid=1 with out_sum=res and out_cout=carry.
//     out_ovf=(opA[W-1]==opB[W-1]) && (res[W-1]!=opA[W-1]).
//     On out_ready at a clock edge: go to IDLE (out_valid drops next cycle).
//     Outputs are held stable while out_ready=0.
//   Timing and handshake rules
//   - Latency: out_valid rises exactly CHUNKS cycles after the accepting edge.
//   - Throughput: one op per CHUNKS+2 cycles at best.
//   - No overlap: in_valid is ignored outside IDLE, even if out_ready is high
//     in the same cycle DONE is left.
//   - Interface protocol: in_a, in_b, in_cin need only be stable on the
//     accepting edge. Once out_valid is asserted, it must not drop without
//     out_ready.
//   Arithmetic
//   - Unsigned wrap within W. out_cout is the true carry out of bit W-1.
//   - out_ovf is the signed overflow of the W-bit add.
//   - The add_* outputs are registered-state driven only. No combinational
//     path exists from add_sum to add_a, add_b or add_cin.
//   - CHUNKS=1 is legal: RUN lasts one cycle.
// TESTING
//   1. N=8,CHUNKS=4: a=0x000000FF,b=0x00000001,cin=0
//      -> out_sum=0x00000100, cout=0, ovf=0; out_valid 4 cycles after accept.
//   2. a=0xFFFFFFFF, b=0x00000000, cin=1
//      -> out_sum=0x00000000, cout=1, ovf=0; carry ripples through all 4 chunks.
//   3. a=0x7FFFFFFF, b=0x00000001, cin=0
//      -> out_sum=0x80000000, cout=0, ovf=1.
//      Also a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
//   4. Hold out_ready=0 for 5 cycles in DONE with in_valid=1:
//      -> out_valid and out_sum stable, in_ready=0, no new op accepted.
//      Release out_ready -> IDLE, then the new op is accepted and correct.
//   5. Assert rst_n=0 while idx=2 in RUN:
//      -> immediately out_valid=0, add_*=0, out_sum=0.
//      After release, in_ready=1 and the next op (a=3, b=4) yields 7.
//   6. N=8,CHUNKS=1: a=254, b=6, cin=0
//      -> out_sum=4, cout=1, ovf=0; out_valid 1 cycle after accept.

Source files
------------

// File: rtl/chunked_add_seq.sv
// Sequencer that feeds one wide operand pair to an external N-bit adder one chunk
// per cycle, LSB chunk first, chaining the carry, and presents the wide result.
module chunked_add_seq #(
  parameter int N      = 8,
  parameter int CHUNKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*CHUNKS-1:0]   in_a,
  input  logic [N*CHUNKS-1:0]   in_b,
  input  logic                  in_cin,
  output logic [N-1:0]          add_a,
  output logic [N-1:0]          add_b,
  output logic                  add_cin,
  input  logic [N-1:0]          add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*CHUNKS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf
);

  localparam int W     = N * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     opa, opb, res;
  logic             carry;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN:  if (idx == LAST) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept; one chunk of result plus carry per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      opa   <= in_a;
      opb   <= in_b;
      carry <= in_cin;
      idx   <= '0;
    end else if (state == RUN) begin
      res[idx*N +: N] <= add_sum;
      carry           <= add_cout;
      if (idx != LAST) idx <= idx + 1'b1;
    end
  end

  // Adder inputs come only from registered state, never from add_sum
  assign add_a   = (state == RUN) ? opa[idx*N +: N] : '0;
  assign add_b   = (state == RUN) ? opb[idx*N +: N] : '0;
  assign add_cin = (state == RUN) ? carry : 1'b0;

  assign out_sum  = res;
  assign out_cout = carry;
  assign out_ovf  = (opa[W-1] == opb[W-1]) && (res[W-1] != opa[W-1]);

endmodule

// File: tb/tb_chunked_add_seq.sv
// Bench for chunked_add_seq: a 4-chunk and a 1-chunk instance, each driving a
// combinational adder, checked against a plain wide-arithmetic reference.
module tb_chunked_add_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-chunk instance
  logic        in_valid, in_ready, in_cin, add_cin, add_cout;
  logic [31:0] in_a, in_b, out_sum;
  logic [7:0]  add_a, add_b, add_sum;
  logic        out_valid, out_ready, out_cout, out_ovf;

  assign {add_cout, add_sum} = add_a + add_b + add_cin;

  chunked_add_seq #(.N(8), .CHUNKS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // 1-chunk instance
  logic       u1_in_valid, u1_in_ready, u1_in_cin, u1_add_cin, u1_add_cout;
  logic [7:0] u1_in_a, u1_in_b, u1_out_sum, u1_add_a, u1_add_b, u1_add_sum;
  logic       u1_out_valid, u1_out_ready, u1_out_cout, u1_out_ovf;

  assign {u1_add_cout, u1_add_sum} = u1_add_a + u1_add_b + u1_add_cin;

  chunked_add_seq #(.N(8), .CHUNKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(u1_in_valid), .in_ready(u1_in_ready),
    .in_a(u1_in_a), .in_b(u1_in_b), .in_cin(u1_in_cin),
    .add_a(u1_add_a), .add_b(u1_add_b), .add_cin(u1_add_cin),
    .add_sum(u1_add_sum), .add_cout(u1_add_cout),
    .out_valid(u1_out_valid), .out_ready(u1_out_ready),
    .out_sum(u1_out_sum), .out_cout(u1_out_cout), .out_ovf(u1_out_ovf)
  );

  int total  = 0;
  int passed = 0;

  logic [31:0] exp_sum;
  logic        exp_cout, exp_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word addition, carry from bit W, overflow from sign rule
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [32:0] full;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    full = {1'b0, a & mask} + {1'b0, b & mask} + 33'(cin);
    exp_sum  = full[31:0] & mask;
    exp_cout = (w == 32) ? full[32] : full[w];
    exp_ovf  = (a[w-1] == b[w-1]) && (exp_sum[w-1] != a[w-1]);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("in_ready_wait", in_ready, 1'b1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    model(32, a, b, cin);
    tick();
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, input int lat_exp);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      chk({tag, "_busy"}, in_ready, 1'b0);
      tick(); lat++;
    end
    chk({tag, "_latency"}, lat, lat_exp);
    chk({tag, "_sum"}, out_sum, exp_sum);
    chk({tag, "_cout"}, out_cout, exp_cout);
    chk({tag, "_ovf"}, out_ovf, exp_ovf);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] a2, b2, ra, rb;
    logic        rc;
    int          lat, hold;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    u1_in_valid = 1'b0; u1_in_a = '0; u1_in_b = '0; u1_in_cin = 1'b0; u1_out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_add_a", add_a, 8'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_done("t1", 4);
    chk("t1_sum_const", out_sum, 32'h0000_0100);
    drain("t1");

    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_done("t2", 4);
    chk("t2_cout_const", out_cout, 1'b1);
    drain("t2");

    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done("t3a", 4);
    chk("t3a_ovf_const", out_ovf, 1'b1);
    drain("t3a");

    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done("t3b", 4);
    drain("t3b");

    // Back-pressure with a pending request that must wait for IDLE
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    wait_done("t4", 4);
    a2 = $urandom; b2 = $urandom;
    in_valid = 1'b1; in_a = a2; in_b = b2; in_cin = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_sum", out_sum, exp_sum);
      chk("t4_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_left_done", out_valid, 1'b0);
    chk("t4_idle_ready", in_ready, 1'b1);
    model(32, a2, b2, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_done("t4_next", 4);
    drain("t4_next");

    // Reset while the third chunk is on the adder
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    tick(); tick();
    chk("t5_chunk2_a", add_a, 8'h34);
    chk("t5_chunk2_b", add_b, 8'hBC);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_add_a", add_a, 8'h0);
    chk("t5_rst_add_b", add_b, 8'h0);
    chk("t5_rst_add_cin", add_cin, 1'b0);
    chk("t5_rst_sum", out_sum, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_ready_after", in_ready, 1'b1);
    send(32'd3, 32'd4, 1'b0);
    wait_done("t5_next", 4);
    chk("t5_seven", out_sum, 32'd7);
    drain("t5_next");

    // Randomised traffic with random consumer stalls
    for (int k = 0; k < 20; k++) begin
      send($urandom, $urandom, 1'($urandom));
      wait_done("rnd", 4);
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("rnd_hold_sum", out_sum, exp_sum);
      end
      drain("rnd");
    end

    // Single-chunk instance
    u1_in_valid = 1'b1; u1_in_a = 8'd254; u1_in_b = 8'd6; u1_in_cin = 1'b0;
    model(8, 32'd254, 32'd6, 1'b0);
    tick();
    u1_in_valid = 1'b0;
    lat = 0;
    while (!u1_out_valid && lat < 20) begin tick(); lat++; end
    chk("t6_latency", lat, 1);
    chk("t6_sum", u1_out_sum, 8'd4);
    chk("t6_cout", u1_out_cout, 1'b1);
    chk("t6_ovf", u1_out_ovf, 1'b0);
    u1_out_ready = 1'b1; tick(); u1_out_ready = 1'b0;
    chk("t6_drop", u1_out_valid, 1'b0);

    for (int k = 0; k < 8; k++) begin
      ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(0, 255)); rc = 1'($urandom);
      u1_in_valid = 1'b1; u1_in_a = ra[7:0]; u1_in_b = rb[7:0]; u1_in_cin = rc;
      model(8, ra, rb, rc);
      tick();
      u1_in_valid = 1'b0;
      lat = 0;
      while (!u1_out_valid && lat < 20) begin tick(); lat++; end
      chk("u1_rnd_latency", lat, 1);
      chk("u1_rnd_sum", u1_out_sum, exp_sum[7:0]);
      chk("u1_rnd_cout", u1_out_cout, exp_cout);
      chk("u1_rnd_ovf", u1_out_ovf, exp_ovf);
      u1_out_ready = 1'b1; tick(); u1_out_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
